// File: rtl/dac_ad5668_pkg.sv
// Shared definitions for the AD5668 frame decoder: command codes, frame field
// positions, FSM encoding and channel-select helpers.
package dac_ad5668_pkg;

  localparam logic [3:0] CMD_WR_IN      = 4'h0;
  localparam logic [3:0] CMD_UPD        = 4'h1;
  localparam logic [3:0] CMD_WR_UPD_ALL = 4'h2;
  localparam logic [3:0] CMD_WR_UPD     = 4'h3;
  localparam logic [3:0] CMD_PWR        = 4'h4;
  localparam logic [3:0] CMD_CLR        = 4'h5;
  localparam logic [3:0] CMD_LDAC       = 4'h6;
  localparam logic [3:0] CMD_RST        = 4'h7;
  localparam logic [3:0] CMD_REF        = 4'h8;

  localparam logic [3:0] ADDR_ALL = 4'hF;

  localparam int CMD_LSB  = 24;
  localparam int ADDR_LSB = 20;
  localparam int DATA_LSB = 4;
  localparam int PD_LSB   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_DECODE  = 2'd2,
    ST_WAIT_HI = 2'd3
  } dec_state_e;

  // Addresses 8..14 name no channel; 15 is the broadcast address.
  function automatic logic addr_illegal(input logic [3:0] addr);
    return (addr >= 4'd8) && (addr != ADDR_ALL);
  endfunction

  function automatic logic [7:0] chan_sel(input logic [3:0] addr);
    logic [7:0] sel;
    if (addr == ADDR_ALL) begin
      sel = 8'hFF;
    end else if (addr < 4'd8) begin
      sel = 8'h01 << addr[2:0];
    end else begin
      sel = 8'h00;
    end
    return sel;
  endfunction

endpackage

// File: rtl/dac_ad5668_frame_decoder_if.sv
// The three AD5668 serial pins as seen by one decoder instance.
interface dac_ad5668_frame_decoder_if;
  logic spi_sclk;
  logic spi_sync_n;
  logic spi_din;

  modport master (output spi_sclk, output spi_sync_n, output spi_din);
  modport slave  (input  spi_sclk, input  spi_sync_n, input  spi_din);
endinterface

// File: rtl/dac_spi_edge_sync.sv
// Synchronizes SCLK/SYNC/DIN into dac_sm_clk and detects SCLK/SYNC edges.
module dac_spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic dac_sm_clk,
  input  logic reset,
  input  logic sclk,
  input  logic sync_n,
  input  logic din,
  output logic sclk_fall,
  output logic sync_fall,
  output logic sync_rise,
  output logic sync_n_s,
  output logic din_s
);

  localparam int MSB = SYNC_STAGES - 1;

  logic [MSB:0] sclk_q, sclk_d;
  logic [MSB:0] sync_q, sync_d;
  logic [MSB:0] din_q,  din_d;
  logic         sclk_last_q, sclk_last_d;
  logic         sync_last_q, sync_last_d;

  always_comb begin
    sclk_d      = {sclk_q[MSB-1:0], sclk};
    sync_d      = {sync_q[MSB-1:0], sync_n};
    din_d       = {din_q[MSB-1:0],  din};
    sclk_last_d = sclk_q[MSB];
    sync_last_d = sync_q[MSB];
  end

  // Clearing to 0 means a SYNC already low at reset release never looks like a fall.
  always_ff @(posedge dac_sm_clk) begin
    if (reset) begin
      sclk_q      <= '0;
      sync_q      <= '0;
      din_q       <= '0;
      sclk_last_q <= 1'b0;
      sync_last_q <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      sync_q      <= sync_d;
      din_q       <= din_d;
      sclk_last_q <= sclk_last_d;
      sync_last_q <= sync_last_d;
    end
  end

  assign sclk_fall = sclk_last_q & ~sclk_q[MSB];
  assign sync_fall = sync_last_q & ~sync_q[MSB];
  assign sync_rise = ~sync_last_q & sync_q[MSB];
  assign sync_n_s  = sync_q[MSB];
  assign din_s     = din_q[MSB];

endmodule

// File: rtl/dac_ad5668_frame_decoder.sv
// AD5668 loopback monitor: captures 32-bit frames and mirrors input/DAC/power-down state.
// Optional DAC_DECODE_ERRCNT_EN adds a saturating err_count output.
module dac_ad5668_frame_decoder
  import dac_ad5668_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 32
) (
  input  logic                        dac_sm_clk,
  input  logic                        reset,
  dac_ad5668_frame_decoder_if.slave   spi,
  output logic [127:0]                input_regs,
  output logic [127:0]                dac_regs,
  output logic [7:0]                  pd_mask,
  output logic                        frame_valid,
  output logic [3:0]                  frame_cmd,
  output logic [3:0]                  frame_addr,
  output logic [15:0]                 frame_data,
  output logic                        frame_err,
  output logic [15:0]                 frame_count
`ifdef DAC_DECODE_ERRCNT_EN
  ,
  output logic [15:0]                 err_count
`endif
);

  logic sclk_fall_s, sync_fall_s, sync_rise_s, sync_n_s, din_s;

  dac_spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .dac_sm_clk (dac_sm_clk),
    .reset      (reset),
    .sclk       (spi.spi_sclk),
    .sync_n     (spi.spi_sync_n),
    .din        (spi.spi_din),
    .sclk_fall  (sclk_fall_s),
    .sync_fall  (sync_fall_s),
    .sync_rise  (sync_rise_s),
    .sync_n_s   (sync_n_s),
    .din_s      (din_s)
  );

  dec_state_e        state_q, state_d;
  logic [31:0]       shift_q, shift_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0][15:0]  in_q, in_d;
  logic [7:0][15:0]  dac_q, dac_d;
  logic [7:0]        pd_q, pd_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [3:0]        addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [15:0]       cnt_q, cnt_d;
`ifdef DAC_DECODE_ERRCNT_EN
  logic [15:0]       errcnt_q, errcnt_d;
`endif

  logic [3:0]  dec_cmd_s, dec_addr_s;
  logic [15:0] dec_data_s;
  logic [7:0]  dec_sel_s;
  logic        dec_pd_s;

  assign dec_cmd_s  = shift_q[CMD_LSB +: 4];
  assign dec_addr_s = shift_q[ADDR_LSB +: 4];
  assign dec_data_s = shift_q[DATA_LSB +: 16];
  assign dec_sel_s  = chan_sel(dec_addr_s);
  assign dec_pd_s   = (shift_q[PD_LSB +: 2] != 2'b00);

  // Frame FSM next-state and command application.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    in_d      = in_q;
    dac_d     = dac_q;
    pd_d      = pd_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sync_fall_s) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = 6'd0;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == 6'(FRAME_BITS)) begin
          state_d = ST_DECODE;
        end else if (sync_rise_s) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (sclk_fall_s) begin
          shift_d   = {shift_q[30:0], din_s};
          bit_cnt_d = bit_cnt_q + 6'd1;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DECODE: begin
        state_d = ST_WAIT_HI;
        valid_d = 1'b1;
        cmd_d   = dec_cmd_s;
        addr_d  = dec_addr_s;
        data_d  = dec_data_s;
        cnt_d   = cnt_q + 16'd1;
        if (addr_illegal(dec_addr_s)) begin
          err_d = 1'b1;
        end else begin
          case (dec_cmd_s)
            CMD_WR_IN: begin
              for (int i = 0; i < 8; i++) if (dec_sel_s[i]) in_d[i] = dec_data_s;
            end
            CMD_UPD: begin
              for (int i = 0; i < 8; i++) if (dec_sel_s[i]) dac_d[i] = in_q[i];
            end
            CMD_WR_UPD_ALL: begin
              for (int i = 0; i < 8; i++) if (dec_sel_s[i]) in_d[i] = dec_data_s;
              dac_d = in_d;
            end
            CMD_WR_UPD: begin
              for (int i = 0; i < 8; i++) begin
                if (dec_sel_s[i]) begin
                  in_d[i]  = dec_data_s;
                  dac_d[i] = dec_data_s;
                end
              end
            end
            CMD_PWR: begin
              for (int i = 0; i < 8; i++) if (shift_q[i]) pd_d[i] = dec_pd_s;
            end
            CMD_LDAC: begin
              for (int i = 0; i < 8; i++) if (shift_q[i]) dac_d[i] = in_q[i];
            end
            CMD_RST: begin
              in_d  = '0;
              dac_d = '0;
              pd_d  = 8'h00;
            end
            default: begin
              pd_d = pd_q;
            end
          endcase
        end
      end
      ST_WAIT_HI: begin
        if (sync_n_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HI;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef DAC_DECODE_ERRCNT_EN
  // Saturating count of error pulses.
  always_comb begin
    if (err_d && (errcnt_q != 16'hFFFF)) begin
      errcnt_d = errcnt_q + 16'd1;
    end else begin
      errcnt_d = errcnt_q;
    end
  end
`endif

  // State and registered outputs.
  always_ff @(posedge dac_sm_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= 32'h0;
      bit_cnt_q <= 6'd0;
      in_q      <= '0;
      dac_q     <= '0;
      pd_q      <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      cmd_q     <= 4'h0;
      addr_q    <= 4'h0;
      data_q    <= 16'h0;
      cnt_q     <= 16'h0;
`ifdef DAC_DECODE_ERRCNT_EN
      errcnt_q  <= 16'h0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      in_q      <= in_d;
      dac_q     <= dac_d;
      pd_q      <= pd_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
`ifdef DAC_DECODE_ERRCNT_EN
      errcnt_q  <= errcnt_d;
`endif
    end
  end

  assign input_regs  = in_q;
  assign dac_regs    = dac_q;
  assign pd_mask     = pd_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign frame_cmd   = cmd_q;
  assign frame_addr  = addr_q;
  assign frame_data  = data_q;
  assign frame_count = cnt_q;
`ifdef DAC_DECODE_ERRCNT_EN
  assign err_count   = errcnt_q;
`endif

endmodule

// File: tb/tb_dac_ad5668_frame_decoder.sv
// Directed-vector bench for dac_ad5668_frame_decoder; drives frames bit by bit on the pins.
module tb_dac_ad5668_frame_decoder;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] input_regs, dac_regs;
  logic [7:0]   pd_mask;
  logic         frame_valid, frame_err;
  logic [3:0]   frame_cmd, frame_addr;
  logic [15:0]  frame_data, frame_count;
`ifdef DAC_DECODE_ERRCNT_EN
  logic [15:0]  err_count;
`endif

  int n_vec = 0;
  int n_miscmp = 0;
  int n_valid = 0;
  int n_err = 0;

  dac_ad5668_frame_decoder_if spi_if ();

  dac_ad5668_frame_decoder dut (
    .dac_sm_clk  (clk),
    .reset       (reset),
    .spi         (spi_if),
    .input_regs  (input_regs),
    .dac_regs    (dac_regs),
    .pd_mask     (pd_mask),
    .frame_valid (frame_valid),
    .frame_cmd   (frame_cmd),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .frame_count (frame_count)
`ifdef DAC_DECODE_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Count pulse-cycles so a stuck or missing pulse shows up in the totals.
  always @(negedge clk) begin
    if (frame_valid) n_valid <= n_valid + 1;
    if (frame_err)   n_err   <= n_err + 1;
  end

  task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits);
    spi_if.spi_sync_n = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      spi_if.spi_din  = w[31-i];
      spi_if.spi_sclk = 1'b1;
      tick(3);
      spi_if.spi_sclk = 1'b0;
      tick(3);
    end
    spi_if.spi_sclk = 1'b1;
    tick(3);
  endtask

  task automatic end_frame();
    spi_if.spi_sync_n = 1'b1;
    tick(6);
  endtask

  task automatic send_frame(input logic [31:0] w, input int extra);
    send_bits(w, 32);
    for (int i = 0; i < extra; i++) begin
      spi_if.spi_din  = ~spi_if.spi_din;
      spi_if.spi_sclk = 1'b0;
      tick(3);
      spi_if.spi_sclk = 1'b1;
      tick(3);
    end
    end_frame();
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, "_in"},  input_regs, 128'h0);
    check_vec({tag, "_dac"}, dac_regs, 128'h0);
    check_vec({tag, "_misc"}, {frame_valid, frame_err, pd_mask, frame_cmd, frame_addr, frame_data, frame_count}, 128'h0);
`ifdef DAC_DECODE_ERRCNT_EN
    check_vec({tag, "_errcnt"}, err_count, 128'h0);
`endif
  endtask

  initial begin
    reset = 1'b1;
    spi_if.spi_sclk   = 1'b1;
    spi_if.spi_sync_n = 1'b1;
    spi_if.spi_din    = 1'b0;
    tick(4);
    check_all_zero("reset");
    reset = 1'b0;
    tick(6);

    // 1: write+update ch C, with extra SCLKs ignored in WAIT_HI
    send_frame(32'h032ABCD0, 2);
    check_vec("t1_in",  input_regs, {80'h0, 16'hABCD, 32'h0});
    check_vec("t1_dac", dac_regs,   {80'h0, 16'hABCD, 32'h0});
    check_vec("t1_cnt", frame_count, 128'd1);
    check_vec("t1_valid", n_valid, 128'd1);
    check_vec("t1_fields", {frame_cmd, frame_addr, frame_data}, 128'h32ABCD);

    // 2: clear, broadcast input write, then update ch F only
    send_frame(32'h07000000, 0);
    check_vec("t2_clr", {input_regs, dac_regs}, 256'h0);
    send_frame(32'h00F12340, 0);
    send_frame(32'h01500000, 0);
    check_vec("t2_in",  input_regs, {8{16'h1234}});
    check_vec("t2_dac", dac_regs,   {32'h0, 16'h1234, 80'h0});
    check_vec("t2_cnt", frame_count, 128'd4);

    // 3: short frame after 20 bits, then a good write+update-all
    send_bits(32'h03012222, 20);
    end_frame();
    check_vec("t3_err", n_err, 128'd1);
    check_vec("t3_in",  input_regs, {8{16'h1234}});
    check_vec("t3_dac", dac_regs,   {32'h0, 16'h1234, 80'h0});
    check_vec("t3_cnt", frame_count, 128'd4);
`ifdef DAC_DECODE_ERRCNT_EN
    check_vec("t3_errcnt", err_count, 128'd1);
`endif
    send_frame(32'h027BEEF0, 0);
    check_vec("t3_in2",  input_regs, {16'hBEEF, {7{16'h1234}}});
    check_vec("t3_dac2", dac_regs,   {16'hBEEF, {7{16'h1234}}});
    check_vec("t3_cnt2", frame_count, 128'd5);

    // 4: power-down mask
    send_frame(32'h040001C0, 0);
    check_vec("t4_pd1", pd_mask, 128'hC0);
    send_frame(32'h04000040, 0);
    check_vec("t4_pd2", pd_mask, 128'h80);

    // 5: illegal address
    send_frame(32'h03955550, 0);
    check_vec("t5_err", n_err, 128'd2);
    check_vec("t5_valid", n_valid, 128'd8);
    check_vec("t5_regs", {input_regs, dac_regs}, {{16'hBEEF, {7{16'h1234}}}, {16'hBEEF, {7{16'h1234}}}});
    check_vec("t5_cnt", frame_count, 128'd8);
`ifdef DAC_DECODE_ERRCNT_EN
    check_vec("t5_errcnt", err_count, 128'd2);
`endif

    // LDAC mask loads ch A only, ch B input stays pending
    send_frame(32'h00011110, 0);
    send_frame(32'h00122220, 0);
    send_frame(32'h06000001, 0);
    check_vec("ldac_in",  input_regs, {16'hBEEF, {5{16'h1234}}, 16'h2222, 16'h1111});
    check_vec("ldac_dac", dac_regs,   {16'hBEEF, {6{16'h1234}}, 16'h1111});
    check_vec("ldac_cnt", frame_count, 128'd11);

    // 6: reset mid-frame, then a normal frame
    send_bits(32'h03112340, 16);
    reset = 1'b1;
    tick(3);
    check_all_zero("t6_rst");
    reset = 1'b0;
    spi_if.spi_sync_n = 1'b1;
    tick(6);
    check_all_zero("t6_post");
    check_vec("t6_err", n_err, 128'd2);
    send_frame(32'h032ABCD0, 0);
    check_vec("t6_in",  input_regs, {80'h0, 16'hABCD, 32'h0});
    check_vec("t6_dac", dac_regs,   {80'h0, 16'hABCD, 32'h0});
    check_vec("t6_cnt", frame_count, 128'd1);
    check_vec("t6_valid", n_valid, 128'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
